// File: rtl/cc_pkg.sv
// Shared types and constants for the cache-controller lookup dispatch path.
//   dispatch_state_t : dispatch FSM states
//   hit_data_t       : payload pushed to the hit-data FIFO ({offset, line})
package cc_pkg;

  localparam int unsigned LINE_W = 512;
  localparam int unsigned OFS_W  = 6;
  localparam int unsigned DATA_W = OFS_W + LINE_W;
  localparam int unsigned CNT_W  = 3;

  localparam logic [3:0] BEAT_LEN   = 4'd7;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [2:0] SIZE_8B    = 3'd3;

  typedef enum logic {
    S_IDLE,
    S_AR
  } dispatch_state_t;

  typedef struct packed {
    logic [OFS_W-1:0]  ofs;
    logic [LINE_W-1:0] line;
  } hit_data_t;

endpackage

// File: rtl/cc_outstanding_cnt.sv
// Outstanding-miss counter: +1 per accepted miss, -1 per completed memory
// R burst, with a combinational "room for one more" compare used to gate
// lookup acceptance.
//   clk, rst_n : clock, async active-low reset
//   inc        : miss accepted this cycle
//   dec        : R burst completed this cycle (rvalid & rready & rlast)
//   count      : registered outstanding count
//   room_c     : count < MAX_OUTSTANDING (combinational)
module cc_outstanding_cnt
  import cc_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned WIDTH           = CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             room_c
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count; simultaneous inc/dec cancel out.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({inc, dec})
      2'b10:   cnt_d = cnt_q + WIDTH'(1);
      2'b01:   if (cnt_q != '0) cnt_d = cnt_q - WIDTH'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count  = cnt_q;
  assign room_c = (cnt_q < WIDTH'(MAX_OUTSTANDING));

  // A completion with nothing outstanding means the memory side is broken.
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(dec && !inc && (cnt_q == '0)));

  // Ready gating must keep the count from exceeding the limit.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(inc && !dec && (cnt_q >= WIDTH'(MAX_OUTSTANDING))));

endmodule

// File: rtl/cc_lookup_dispatch_ctrl.sv
// Read-response dispatch for the cache controller. Takes one tag-lookup
// result per transaction: hits push flag=1 plus {offset, line} into the hit
// FIFOs; misses push flag=0 and issue a critical-word-first WRAP AR burst.
// The flag FIFO order defines the response order on the INCT R channel.
//   lookup_*        : lookup result handshake (valid/ready), hit, addr, line
//   hit_flag_fifo_* : flag FIFO afull in, push/wdata out
//   hit_data_fifo_* : data FIFO afull in, push/{addr[5:0], line} out
//   mem_ar*         : AXI AR channel to memory
//   mem_r*          : monitored memory R handshake (burst completion)
//   outstanding_o   : misses whose R burst has not yet completed
module cc_lookup_dispatch_ctrl
  import cc_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ADDR_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_valid_i,
  output logic                  lookup_ready_o,
  input  logic                  lookup_hit_i,
  input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
  input  logic [LINE_W-1:0]     lookup_line_i,
  input  logic                  hit_flag_fifo_afull_i,
  output logic                  hit_flag_fifo_wren_o,
  output logic                  hit_flag_fifo_wdata_o,
  input  logic                  hit_data_fifo_afull_i,
  output logic                  hit_data_fifo_wren_o,
  output logic [DATA_W-1:0]     hit_data_fifo_wdata_o,
  output logic [ADDR_WIDTH-1:0] mem_araddr_o,
  output logic [3:0]            mem_arlen_o,
  output logic [2:0]            mem_arsize_o,
  output logic [1:0]            mem_arburst_o,
  output logic                  mem_arvalid_o,
  input  logic                  mem_arready_i,
  input  logic                  mem_rvalid_i,
  input  logic                  mem_rready_i,
  input  logic                  mem_rlast_i,
  output logic [CNT_W-1:0]      outstanding_o
);

  dispatch_state_t       state_q, state_d;
  logic                  flag_wren_q, flag_wren_d;
  logic                  flag_wdata_q, flag_wdata_d;
  logic                  data_wren_q, data_wren_d;
  hit_data_t             data_q, data_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [3:0]            arlen_q, arlen_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [1:0]            arburst_q, arburst_d;
  logic                  arvalid_q, arvalid_d;

  logic room_c;
  logic accept_c;
  logic miss_accept_c;
  logic r_done_c;

  // Accept only in IDLE with room in both FIFOs and below the miss limit.
  assign lookup_ready_o = (state_q == S_IDLE) && !hit_flag_fifo_afull_i &&
                          !hit_data_fifo_afull_i && room_c;
  assign accept_c       = lookup_valid_i && lookup_ready_o;
  assign miss_accept_c  = accept_c && !lookup_hit_i;
  assign r_done_c       = mem_rvalid_i && mem_rready_i && mem_rlast_i;

  cc_outstanding_cnt #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .WIDTH           (CNT_W)
  ) u_outstanding_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (miss_accept_c),
    .dec    (r_done_c),
    .count  (outstanding_o),
    .room_c (room_c)
  );

  // Next-state and next-output logic; pushes are single-cycle pulses.
  always_comb begin
    state_d      = state_q;
    flag_wren_d  = 1'b0;
    flag_wdata_d = flag_wdata_q;
    data_wren_d  = 1'b0;
    data_d       = data_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arsize_d     = arsize_q;
    arburst_d    = arburst_q;
    arvalid_d    = arvalid_q;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          flag_wren_d  = 1'b1;
          flag_wdata_d = lookup_hit_i;
          if (lookup_hit_i) begin
            data_wren_d = 1'b1;
            data_d.ofs  = lookup_addr_i[OFS_W-1:0];
            data_d.line = lookup_line_i;
          end else begin
            // WRAP burst from the 8-byte word holding the requested byte.
            araddr_d  = {lookup_addr_i[ADDR_WIDTH-1:3], 3'b000};
            arlen_d   = BEAT_LEN;
            arsize_d  = SIZE_8B;
            arburst_d = BURST_WRAP;
            arvalid_d = 1'b1;
            state_d   = S_AR;
          end
        end
      end
      S_AR: begin
        if (mem_arready_i) begin
          arvalid_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        arvalid_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      flag_wren_q  <= 1'b0;
      flag_wdata_q <= 1'b0;
      data_wren_q  <= 1'b0;
      data_q       <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arburst_q    <= '0;
      arvalid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      flag_wren_q  <= flag_wren_d;
      flag_wdata_q <= flag_wdata_d;
      data_wren_q  <= data_wren_d;
      data_q       <= data_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
      arburst_q    <= arburst_d;
      arvalid_q    <= arvalid_d;
    end
  end

  assign hit_flag_fifo_wren_o  = flag_wren_q;
  assign hit_flag_fifo_wdata_o = flag_wdata_q;
  assign hit_data_fifo_wren_o  = data_wren_q;
  assign hit_data_fifo_wdata_o = data_q;
  assign mem_araddr_o          = araddr_q;
  assign mem_arlen_o           = arlen_q;
  assign mem_arsize_o          = arsize_q;
  assign mem_arburst_o         = arburst_q;
  assign mem_arvalid_o         = arvalid_q;

endmodule

// File: tb/tb_cc_lookup_dispatch_ctrl.sv
// Self-checking bench for cc_lookup_dispatch_ctrl: a table of single-cycle
// hit / afull vectors plus hand-written miss, limit and reset sequences.
module tb_cc_lookup_dispatch_ctrl;

  logic          clk;
  logic          rst_n;
  logic          lookup_valid;
  logic          lookup_ready;
  logic          lookup_hit;
  logic [31:0]   lookup_addr;
  logic [511:0]  lookup_line;
  logic          flag_afull;
  logic          flag_wren;
  logic          flag_wdata;
  logic          data_afull;
  logic          data_wren;
  logic [517:0]  data_wdata;
  logic [31:0]   araddr;
  logic [3:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready;
  logic          rvalid;
  logic          rready;
  logic          rlast;
  logic [2:0]    outstanding;

  int pass_cnt  = 0;
  int total_cnt = 0;

  cc_lookup_dispatch_ctrl #(
    .MAX_OUTSTANDING (4),
    .ADDR_WIDTH      (32)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .lookup_valid_i        (lookup_valid),
    .lookup_ready_o        (lookup_ready),
    .lookup_hit_i          (lookup_hit),
    .lookup_addr_i         (lookup_addr),
    .lookup_line_i         (lookup_line),
    .hit_flag_fifo_afull_i (flag_afull),
    .hit_flag_fifo_wren_o  (flag_wren),
    .hit_flag_fifo_wdata_o (flag_wdata),
    .hit_data_fifo_afull_i (data_afull),
    .hit_data_fifo_wren_o  (data_wren),
    .hit_data_fifo_wdata_o (data_wdata),
    .mem_araddr_o          (araddr),
    .mem_arlen_o           (arlen),
    .mem_arsize_o          (arsize),
    .mem_arburst_o         (arburst),
    .mem_arvalid_o         (arvalid),
    .mem_arready_i         (arready),
    .mem_rvalid_i          (rvalid),
    .mem_rready_i          (rready),
    .mem_rlast_i           (rlast),
    .outstanding_o         (outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        flag_af;
    logic        data_af;
    logic        valid;
    logic [31:0] addr;
    logic        exp_ready;
    logic        exp_push;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_data(input string name, input logic [517:0] act, input logic [517:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a miss, wait (bounded) for ready, accept it and check the AR.
  task automatic accept_miss(input logic [31:0] a);
    int n;
    lookup_valid = 1'b1;
    lookup_hit   = 1'b0;
    lookup_addr  = a;
    #1;
    n = 0;
    while (!lookup_ready && n < 20) begin
      step();
      n++;
    end
    if (n == 20) chk("miss_ready_timeout", 64'(lookup_ready), 64'd1);
    step();
    lookup_valid = 1'b0;
    chk("miss_flag_wren", 64'(flag_wren), 64'd1);
    chk("miss_flag_wdata", 64'(flag_wdata), 64'd0);
    chk("miss_data_wren", 64'(data_wren), 64'd0);
    chk("miss_arvalid", 64'(arvalid), 64'd1);
    chk("miss_araddr", 64'(araddr), 64'({a[31:3], 3'b000}));
    chk("miss_arlen", 64'(arlen), 64'd7);
    chk("miss_arsize", 64'(arsize), 64'd3);
    chk("miss_arburst", 64'(arburst), 64'd2);
  endtask

  task automatic complete_ar();
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("ar_done_arvalid", 64'(arvalid), 64'd0);
  endtask

  task automatic rlast_pulse();
    rvalid = 1'b1;
    rready = 1'b1;
    rlast  = 1'b1;
    step();
    rvalid = 1'b0;
    rready = 1'b0;
    rlast  = 1'b0;
  endtask

  initial begin
    logic [511:0] line;

    // Table: all hits; exp_push = accepted this cycle.
    vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h1000_0028, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_003F, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h1111_0004, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h2222_0008, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h3333_000C, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h4444_0010, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFC0, 1'b1, 1'b1};

    rst_n        = 1'b0;
    lookup_valid = 1'b0;
    lookup_hit   = 1'b0;
    lookup_addr  = '0;
    lookup_line  = '0;
    flag_afull   = 1'b0;
    data_afull   = 1'b0;
    arready      = 1'b0;
    rvalid       = 1'b0;
    rready       = 1'b0;
    rlast        = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_flag_wren", 64'(flag_wren), 64'd0);
    chk("rst_data_wren", 64'(data_wren), 64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_araddr", 64'(araddr), 64'd0);
    chk("rst_arlen", 64'(arlen), 64'd0);
    chk_data("rst_data_wdata", data_wdata, 518'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 64'(lookup_ready), 64'd1);

    // Table-driven hit / afull vectors
    for (int i = 0; i < 7; i++) begin
      line         = {16{vecs[i].addr ^ 32'hDEAD_BEEF}};
      flag_afull   = vecs[i].flag_af;
      data_afull   = vecs[i].data_af;
      lookup_valid = vecs[i].valid;
      lookup_hit   = 1'b1;
      lookup_addr  = vecs[i].addr;
      lookup_line  = line;
      #1;
      chk($sformatf("vec%0d_ready", i), 64'(lookup_ready), 64'(vecs[i].exp_ready));
      step();
      lookup_valid = 1'b0;
      flag_afull   = 1'b0;
      data_afull   = 1'b0;
      chk($sformatf("vec%0d_flag_wren", i), 64'(flag_wren), 64'(vecs[i].exp_push));
      chk($sformatf("vec%0d_data_wren", i), 64'(data_wren), 64'(vecs[i].exp_push));
      chk($sformatf("vec%0d_arvalid", i), 64'(arvalid), 64'd0);
      if (vecs[i].exp_push) begin
        chk($sformatf("vec%0d_flag_wdata", i), 64'(flag_wdata), 64'd1);
        chk_data($sformatf("vec%0d_data_wdata", i), data_wdata, {vecs[i].addr[5:0], line});
      end
    end
    step();
    chk("hit_pulse_ends", 64'(flag_wren), 64'd0);

    // Flag afull holds off a pending hit, then it goes through
    flag_afull   = 1'b1;
    lookup_valid = 1'b1;
    lookup_hit   = 1'b1;
    lookup_addr  = 32'h0ABC_0015;
    #1;
    chk("afull_ready", 64'(lookup_ready), 64'd0);
    step();
    chk("afull_no_wren", 64'(flag_wren), 64'd0);
    flag_afull = 1'b0;
    #1;
    chk("afull_release_ready", 64'(lookup_ready), 64'd1);
    step();
    lookup_valid = 1'b0;
    chk("afull_release_wren", 64'(flag_wren), 64'd1);
    chk("afull_release_wdata", 64'(flag_wdata), 64'd1);
    chk("afull_release_ofs", 64'(data_wdata[517:512]), 64'h15);

    // Miss with AR stalled for 5 cycles
    accept_miss(32'h2000_0038);
    chk("miss1_count", 64'(outstanding), 64'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("stall%0d_arvalid", k), 64'(arvalid), 64'd1);
      chk($sformatf("stall%0d_araddr", k), 64'(araddr), 64'h2000_0038);
      chk($sformatf("stall%0d_arlen", k), 64'(arlen), 64'd7);
      chk($sformatf("stall%0d_arburst", k), 64'(arburst), 64'd2);
      chk($sformatf("stall%0d_ready", k), 64'(lookup_ready), 64'd0);
      chk($sformatf("stall%0d_flag_wren", k), 64'(flag_wren), 64'd0);
    end
    complete_ar();
    chk("after_ar_ready", 64'(lookup_ready), 64'd1);

    // Outstanding limit
    rlast_pulse();
    chk("drain_count", 64'(outstanding), 64'd0);
    for (int i = 0; i < 4; i++) begin
      accept_miss(32'h3000_0000 + 32'(i * 64) + 32'h3C);
      chk($sformatf("lim_count%0d", i), 64'(outstanding), 64'(i + 1));
      complete_ar();
    end
    lookup_valid = 1'b1;
    lookup_hit   = 1'b0;
    lookup_addr  = 32'h3000_0100;
    #1;
    chk("full_ready", 64'(lookup_ready), 64'd0);
    step();
    chk("full_ready2", 64'(lookup_ready), 64'd0);
    chk("full_no_wren", 64'(flag_wren), 64'd0);
    chk("full_count", 64'(outstanding), 64'd4);
    rlast_pulse();
    chk("rlast_count", 64'(outstanding), 64'd3);
    chk("rlast_ready", 64'(lookup_ready), 64'd1);
    step();
    lookup_valid = 1'b0;
    chk("fifth_flag_wren", 64'(flag_wren), 64'd1);
    chk("fifth_flag_wdata", 64'(flag_wdata), 64'd0);
    chk("fifth_arvalid", 64'(arvalid), 64'd1);
    chk("fifth_araddr", 64'(araddr), 64'h3000_0100);
    chk("fifth_count", 64'(outstanding), 64'd4);
    complete_ar();

    // Miss accept coinciding with an rlast handshake at count 2
    rlast_pulse();
    rlast_pulse();
    chk("pre_simul_count", 64'(outstanding), 64'd2);
    lookup_valid = 1'b1;
    lookup_hit   = 1'b0;
    lookup_addr  = 32'h4000_0017;
    rvalid       = 1'b1;
    rready       = 1'b1;
    rlast        = 1'b1;
    #1;
    chk("simul_ready", 64'(lookup_ready), 64'd1);
    step();
    lookup_valid = 1'b0;
    rvalid       = 1'b0;
    rready       = 1'b0;
    rlast        = 1'b0;
    chk("simul_count", 64'(outstanding), 64'd2);
    chk("simul_arvalid", 64'(arvalid), 64'd1);
    chk("simul_araddr", 64'(araddr), 64'h4000_0010);
    complete_ar();

    // Asynchronous reset while the AR is pending
    accept_miss(32'h5000_0008);
    chk("pre_rst_count", 64'(outstanding), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_arvalid", 64'(arvalid), 64'd0);
    chk("async_rst_count", 64'(outstanding), 64'd0);
    chk("async_rst_flag_wren", 64'(flag_wren), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_async_arvalid", 64'(arvalid), 64'd0);
    chk("post_async_ready", 64'(lookup_ready), 64'd1);
    lookup_valid = 1'b1;
    lookup_hit   = 1'b1;
    lookup_addr  = 32'h6000_0021;
    step();
    lookup_valid = 1'b0;
    chk("post_async_hit_wren", 64'(flag_wren), 64'd1);
    chk("post_async_hit_ofs", 64'(data_wdata[517:512]), 64'h21);
    chk("post_async_count", 64'(outstanding), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
